// File: rtl/ov7670_capture_ctl.sv
// OV7670 capture controller.
// Pairs camera bytes into RGB565 words and writes them to a frame buffer.
// Optional 2x decimation keeps only even rows and even columns.
// Capture is started by a one-shot arm pulse or the continuous level.
// Two flags report geometry problems: line_err for a bad line, frame_err for a wrong write count.
module ov7670_capture_ctl #(
    parameter int H_ACTIVE  = 320,
    parameter int V_ACTIVE  = 240,
    parameter int DEC       = 1,
    parameter int BYTE_SWAP = 0,
    parameter int ADDR_W    = 17
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic              arm,
    input  logic              continuous,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       dout,
    output logic              we,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              line_err,
    output logic              frame_err
);

    localparam int DEPTH = (H_ACTIVE / DEC) * (V_ACTIVE / DEC);
    localparam int XW    = $clog2(H_ACTIVE + 1);
    localparam int YW    = $clog2(V_ACTIVE + 1);
    // One bit wider than the address so the count can reach DEPTH itself.
    localparam int CW    = ADDR_W + 1;

    localparam logic [XW-1:0] X_MAX   = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_MAX   = YW'(V_ACTIVE);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        ACTIVE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic          vsync_q;
    logic          href_q;
    logic          phase;
    logic [7:0]    held;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] wcnt;

    logic          vs_fall;
    logic          vs_rise;
    logic          href_fall;
    logic          in_active;
    logic          enter_active;
    logic          pix_done;
    logic          keep;
    logic          write_ok;
    logic          line_end;
    logic [15:0]   pixel;

    assign vs_fall      = vsync_q & ~vsync;
    assign vs_rise      = ~vsync_q & vsync;
    assign href_fall    = href_q & ~href;
    assign in_active    = (state == ACTIVE);
    assign enter_active = (state == WAIT_VS) & vs_fall;

    // The second byte of a pair completes a pixel.
    assign pix_done = href & phase;
    assign pixel    = (BYTE_SWAP != 0) ? {d, held} : {held, d};

    // With decimation only even columns of even rows survive.
    assign keep = (DEC == 2) ? (~x[0] & ~y[0]) : 1'b1;

    // A byte arriving on the cycle the frame closes is dropped.
    // This keeps we from appearing in DONE.
    assign write_ok = in_active & ~vs_rise & pix_done & keep & (wcnt < DEPTH_C);

    // A vsync rise in the middle of a line also closes that line.
    assign line_end = in_active & (href_fall | (vs_rise & (href_q | href)));

    // Delay vsync and href by one cycle for edge detection.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= vsync;
            href_q  <= href;
        end
    end

    // Capture state register.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // Arming is only honoured in IDLE, so arm while busy has no effect.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arm || continuous) state_next = WAIT_VS;
            WAIT_VS: if (vs_fall)           state_next = ACTIVE;
            ACTIVE:  if (vs_rise)           state_next = DONE;
            DONE:    state_next = continuous ? WAIT_VS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            WAIT_VS: busy       = 1'b1;
            ACTIVE:  busy       = 1'b1;
            DONE:    frame_done = 1'b1;
            default: ;
        endcase
    end

    // Byte pairing, position counters, BRAM write port and error flags.
    // Later assignments intentionally override earlier ones.
    // Example: a line end resets x after a pixel bumped it in the same cycle.
    always_ff @(posedge pclk) begin
        if (rst) begin
            phase     <= 1'b0;
            held      <= 8'd0;
            x         <= '0;
            y         <= '0;
            wcnt      <= '0;
            addr      <= '0;
            dout      <= 16'd0;
            we        <= 1'b0;
            frame_cnt <= 8'd0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            we <= 1'b0;

            if (href) begin
                phase <= ~phase;
                if (!phase) begin
                    held <= d;
                end
            end else begin
                phase <= 1'b0;
            end

            if (enter_active) begin
                x         <= '0;
                y         <= '0;
                wcnt      <= '0;
                phase     <= 1'b0;
                addr      <= '0;
                line_err  <= 1'b0;
                frame_err <= 1'b0;
            end else if (in_active) begin
                if (pix_done && (x != X_MAX)) begin
                    x <= x + XW'(1);
                end

                if (write_ok) begin
                    we   <= 1'b1;
                    dout <= pixel;
                    addr <= wcnt[ADDR_W-1:0];
                    wcnt <= wcnt + CW'(1);
                end

                if (line_end) begin
                    if ((x != X_MAX) || phase) begin
                        line_err <= 1'b1;
                    end
                    x <= '0;
                    if (y != Y_MAX) begin
                        y <= y + YW'(1);
                    end
                end

                if (vs_rise) begin
                    frame_cnt <= frame_cnt + 8'd1;
                    if (wcnt != DEPTH_C) begin
                        frame_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture_ctl.sv
// Testbench for ov7670_capture_ctl.
// Two instances share the same camera stimulus:
//   dut0: no decimation, first byte in the high half.
//   dut1: 2x decimation, first byte in the low half.
// The geometry is shrunk to 16x8 so whole frames stay short.
module tb_ov7670_capture_ctl;

    localparam int H      = 16;
    localparam int V      = 8;
    localparam int AW0    = 7;
    localparam int AW1    = 5;
    localparam int DEPTH0 = H * V;
    localparam int DEPTH1 = (H / 2) * (V / 2);
    localparam int MAXL   = 16;
    localparam int MAXB   = 40;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       vsync = 1'b1;
    logic       href = 1'b0;
    logic [7:0] d = 8'd0;
    logic       arm = 1'b0;
    logic       continuous = 1'b0;

    logic [AW0-1:0] addr0;
    logic [AW1-1:0] addr1;
    logic [15:0]    dout0, dout1;
    logic           we0, we1, busy0, busy1, fd0, fd1, le0, le1, fe0, fe1;
    logic [7:0]     fc0, fc1;

    ov7670_capture_ctl #(.H_ACTIVE(H), .V_ACTIVE(V), .DEC(1), .BYTE_SWAP(0), .ADDR_W(AW0)) dut0 (
        .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d), .arm(arm),
        .continuous(continuous), .addr(addr0), .dout(dout0), .we(we0), .busy(busy0),
        .frame_done(fd0), .frame_cnt(fc0), .line_err(le0), .frame_err(fe0)
    );

    ov7670_capture_ctl #(.H_ACTIVE(H), .V_ACTIVE(V), .DEC(2), .BYTE_SWAP(1), .ADDR_W(AW1)) dut1 (
        .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .d(d), .arm(arm),
        .continuous(continuous), .addr(addr1), .dout(dout1), .we(we1), .busy(busy1),
        .frame_done(fd1), .frame_cnt(fc1), .line_err(le1), .frame_err(fe1)
    );

    always #5 pclk = ~pclk;

    // Per-instance views so checks can loop over both DUTs.
    int          addr_o [2];
    logic [15:0] dout_o [2];
    logic        we_o [2], busy_o [2], fd_o [2], le_o [2], fe_o [2];
    logic [7:0]  fc_o [2];
    logic [63:0] obs_all [2];

    assign addr_o[0] = int'(addr0);
    assign addr_o[1] = int'(addr1);
    assign dout_o[0] = dout0;
    assign dout_o[1] = dout1;
    assign we_o[0]   = we0;
    assign we_o[1]   = we1;
    assign busy_o[0] = busy0;
    assign busy_o[1] = busy1;
    assign fd_o[0]   = fd0;
    assign fd_o[1]   = fd1;
    assign le_o[0]   = le0;
    assign le_o[1]   = le1;
    assign fe_o[0]   = fe0;
    assign fe_o[1]   = fe1;
    assign fc_o[0]   = fc0;
    assign fc_o[1]   = fc1;
    assign obs_all[0] = {3'b0, addr_o[0], dout0, we0, busy0, fd0, fc0, le0, fe0};
    assign obs_all[1] = {3'b0, addr_o[1], dout1, we1, busy1, fd1, fc1, le1, fe1};

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int cd_edge = 0;

    // Frame description: bytes of each line and line lengths.
    logic [7:0] byte_mem [MAXL][MAXB];
    int         line_len [MAXL];

    // Reference model results, one entry per DUT.
    int exp_q [2][$];
    int exp_n [2];
    int exp_last [2];
    bit exp_le [2];
    bit exp_fe [2];
    int exp_fc = 0;

    // Observations made by the monitor.
    int          wc [2];
    int          fd_cnt [2];
    int          first_edge [2];
    logic [15:0] first_data [2];
    logic [63:0] snap [2];
    int          sb_exp;

    // Monitor and scoreboard.
    // Outputs are sampled 1 time unit after each rising edge.
    // Every write is matched in order against the model's queue.
    always @(posedge pclk) begin
        edge_cnt++;
        #1;
        for (int w = 0; w < 2; w++) begin
            if (we_o[w] === 1'b1) begin
                if (wc[w] == 0) begin
                    first_data[w] = dout_o[w];
                    first_edge[w] = edge_cnt;
                end
                wc[w]++;
                checks++;
                if (exp_q[w].size() == 0) begin
                    errors++;
                    $display("[TB] FAIL write_dut%0d got addr=%0d dout=%h required no write",
                             w, addr_o[w], dout_o[w]);
                end else begin
                    sb_exp = exp_q[w].pop_front();
                    if (addr_o[w] * 65536 + int'(dout_o[w]) !== sb_exp) begin
                        errors++;
                        $display("[TB] FAIL write_dut%0d got addr=%0d dout=%h required addr=%0d dout=%h",
                                 w, addr_o[w], dout_o[w], sb_exp / 65536, sb_exp % 65536);
                    end
                end
            end
            if (fd_o[w] === 1'b1) fd_cnt[w]++;
        end
    end

    // Builds one frame: every line holds H ideal pixels of random bytes.
    task automatic fill_ideal();
        for (int l = 0; l < MAXL; l++) begin
            line_len[l] = 2 * H;
            for (int b = 0; b < MAXB; b++) byte_mem[l][b] = 8'($urandom);
        end
    endtask

    task automatic clear_counts();
        for (int w = 0; w < 2; w++) begin
            wc[w] = 0;
            fd_cnt[w] = 0;
        end
    endtask

    // Reference model: walks the frame in reading order.
    // A pixel is written when its column and row (each clipped to the
    // active size) are multiples of the decimation factor, while fewer
    // than DEPTH words have been written. Write k goes to address k.
    task automatic model_frame(input int which, input int nlines, input bit capture);
        int dec, depth, cnt, np, xe, ye, v;
        bit le;
        dec   = (which == 0) ? 1 : 2;
        depth = (which == 0) ? DEPTH0 : DEPTH1;
        cnt   = 0;
        le    = 1'b0;
        exp_q[which].delete();
        for (int l = 0; l < nlines; l++) begin
            np = line_len[l] / 2;
            for (int p = 0; p < np; p++) begin
                xe = (p < H) ? p : H;
                ye = (l < V) ? l : V;
                if ((xe % dec == 0) && (ye % dec == 0) && (cnt < depth)) begin
                    if (which == 0) v = int'(byte_mem[l][2*p]) * 256 + int'(byte_mem[l][2*p+1]);
                    else            v = int'(byte_mem[l][2*p+1]) * 256 + int'(byte_mem[l][2*p]);
                    if (capture) exp_q[which].push_back(cnt * 65536 + v);
                    cnt++;
                end
            end
            if (((np < H) ? np : H) != H || (line_len[l] % 2) != 0) le = 1'b1;
        end
        exp_n[which]    = capture ? cnt : 0;
        exp_last[which] = (cnt > 0) ? cnt - 1 : 0;
        exp_le[which]   = le;
        exp_fe[which]   = (cnt != depth);
    endtask

    // Plays one frame on the camera pins.
    // arm_line: -2 pulses arm during leading blanking; otherwise on byte 0 of that line.
    // rst_line: pulses rst halfway through that line and snapshots the outputs.
    // drop_line: clears continuous on byte 0 of that line.
    task automatic send_frame(input int nlines, input int arm_line, input int rst_line, input int drop_line);
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            vsync = 1'b1;
            href  = 1'b0;
            rst   = 1'b0;
            arm   = (arm_line == -2 && i == 1);
        end
        @(negedge pclk);
        vsync = 1'b0;
        arm   = 1'b0;
        repeat (2) @(negedge pclk);
        for (int l = 0; l < nlines; l++) begin
            for (int b = 0; b < line_len[l]; b++) begin
                @(negedge pclk);
                href = 1'b1;
                d    = byte_mem[l][b];
                arm  = (l == arm_line && b == 0);
                if (l == drop_line && b == 0) continuous = 1'b0;
                if (l == 0 && b == 1) cd_edge = edge_cnt + 1;
                if (l == rst_line && b == line_len[l] / 2) begin
                    rst = 1'b1;
                    @(posedge pclk);
                    #1;
                    for (int w = 0; w < 2; w++) begin
                        snap[w] = obs_all[w];
                        exp_q[w].delete();
                        wc[w] = 0;
                        fd_cnt[w] = 0;
                    end
                    exp_fc = 0;
                end else begin
                    rst = 1'b0;
                end
            end
            repeat (3) begin
                @(negedge pclk);
                href = 1'b0;
                arm  = 1'b0;
                rst  = 1'b0;
                d    = 8'($urandom);
            end
        end
        @(negedge pclk);
        vsync = 1'b1;
        repeat (3) @(negedge pclk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge pclk);
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (obs_all[w] !== 64'd0) begin
                errors++;
                $display("[TB] FAIL reset_outputs_dut%0d got %h required 0", w, obs_all[w]);
            end
        end
        rst = 1'b0;
        exp_fc = 0;
        @(negedge pclk);
    endtask

    task automatic test_continuous_frames();
        continuous = 1'b1;
        for (int f = 0; f < 2; f++) begin
            fill_ideal();
            for (int w = 0; w < 2; w++) model_frame(w, V, 1'b1);
            clear_counts();
            send_frame(V, -1, -1, (f == 1) ? V - 1 : -1);
            exp_fc++;
            for (int w = 0; w < 2; w++) begin
                checks++;
                if (wc[w] != ((w == 0) ? DEPTH0 : DEPTH1)) begin
                    errors++;
                    $display("[TB] FAIL cont_writes_dut%0d got %0d required %0d", w, wc[w], (w == 0) ? DEPTH0 : DEPTH1);
                end
                checks++;
                if (exp_q[w].size() != 0 || fd_cnt[w] != 1) begin
                    errors++;
                    $display("[TB] FAIL cont_done_dut%0d got pending=%0d done=%0d required 0 and 1", w, exp_q[w].size(), fd_cnt[w]);
                end
                checks++;
                if (fc_o[w] !== 8'(exp_fc) || le_o[w] !== 1'b0 || fe_o[w] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL cont_status_dut%0d got cnt=%0d le=%b fe=%b required cnt=%0d le=0 fe=0", w, fc_o[w], le_o[w], fe_o[w], exp_fc);
                end
                checks++;
                if (addr_o[w] != exp_last[w]) begin
                    errors++;
                    $display("[TB] FAIL cont_last_addr_dut%0d got %0d required %0d", w, addr_o[w], exp_last[w]);
                end
            end
        end
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (busy_o[w] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL cont_idle_busy_dut%0d got %b required 0", w, busy_o[w]);
            end
        end
    endtask

    task automatic test_byte_swap_latency();
        fill_ideal();
        byte_mem[0][0] = 8'hAB;
        byte_mem[0][1] = 8'hCD;
        for (int w = 0; w < 2; w++) model_frame(w, V, 1'b1);
        clear_counts();
        send_frame(V, -2, -1, -1);
        exp_fc++;
        checks++;
        if (first_data[0] !== 16'hABCD) begin
            errors++;
            $display("[TB] FAIL swap0_dout got %h required abcd", first_data[0]);
        end
        checks++;
        if (first_data[1] !== 16'hCDAB) begin
            errors++;
            $display("[TB] FAIL swap1_dout got %h required cdab", first_data[1]);
        end
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (first_edge[w] != cd_edge) begin
                errors++;
                $display("[TB] FAIL latency_dut%0d got edge %0d required edge %0d", w, first_edge[w], cd_edge);
            end
            checks++;
            if (exp_q[w].size() != 0 || wc[w] != exp_n[w] || fc_o[w] !== 8'(exp_fc)) begin
                errors++;
                $display("[TB] FAIL swap_frame_dut%0d got pending=%0d writes=%0d cnt=%0d required 0 %0d %0d", w, exp_q[w].size(), wc[w], fc_o[w], exp_n[w], exp_fc);
            end
        end
    endtask

    task automatic test_line_errors();
        fill_ideal();
        line_len[2] = 2 * (H - 1);
        line_len[4] = 2 * H + 1;
        for (int w = 0; w < 2; w++) model_frame(w, V, 1'b1);
        clear_counts();
        send_frame(V, -2, -1, -1);
        exp_fc++;
        checks++;
        if (wc[0] != DEPTH0 - 1) begin
            errors++;
            $display("[TB] FAIL short_frame_writes got %0d required %0d", wc[0], DEPTH0 - 1);
        end
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (le_o[w] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL line_err_dut%0d got %b required 1", w, le_o[w]);
            end
            checks++;
            if (fe_o[w] !== exp_fe[w]) begin
                errors++;
                $display("[TB] FAIL frame_err_dut%0d got %b required %b", w, fe_o[w], exp_fe[w]);
            end
            checks++;
            if (exp_q[w].size() != 0 || wc[w] != exp_n[w] || fd_cnt[w] != 1) begin
                errors++;
                $display("[TB] FAIL err_frame_dut%0d got pending=%0d writes=%0d done=%0d required 0 %0d 1", w, exp_q[w].size(), wc[w], fd_cnt[w], exp_n[w]);
            end
        end
    endtask

    task automatic test_arm_midframe();
        continuous = 1'b0;
        fill_ideal();
        for (int w = 0; w < 2; w++) model_frame(w, V, 1'b0);
        clear_counts();
        send_frame(V, 3, -1, -1);
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (wc[w] != 0 || fd_cnt[w] != 0 || busy_o[w] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL partial_frame_dut%0d got writes=%0d done=%0d busy=%b required 0 0 1", w, wc[w], fd_cnt[w], busy_o[w]);
            end
        end
        fill_ideal();
        for (int w = 0; w < 2; w++) model_frame(w, V, 1'b1);
        clear_counts();
        send_frame(V, 2, -1, -1);
        exp_fc++;
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (exp_q[w].size() != 0 || wc[w] != exp_n[w] || fd_cnt[w] != 1) begin
                errors++;
                $display("[TB] FAIL armed_frame_dut%0d got pending=%0d writes=%0d done=%0d required 0 %0d 1", w, exp_q[w].size(), wc[w], fd_cnt[w], exp_n[w]);
            end
            checks++;
            if (busy_o[w] !== 1'b0 || fc_o[w] !== 8'(exp_fc)) begin
                errors++;
                $display("[TB] FAIL armed_after_dut%0d got busy=%b cnt=%0d required 0 %0d", w, busy_o[w], fc_o[w], exp_fc);
            end
        end
        fill_ideal();
        for (int w = 0; w < 2; w++) model_frame(w, V, 1'b0);
        clear_counts();
        send_frame(V, -1, -1, -1);
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (wc[w] != 0 || fd_cnt[w] != 0 || busy_o[w] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ignored_arm_dut%0d got writes=%0d done=%0d busy=%b required 0 0 0", w, wc[w], fd_cnt[w], busy_o[w]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        fill_ideal();
        for (int w = 0; w < 2; w++) model_frame(w, V, 1'b1);
        clear_counts();
        send_frame(V, -2, 3, -1);
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (snap[w] !== 64'd0) begin
                errors++;
                $display("[TB] FAIL midreset_outputs_dut%0d got %h required 0", w, snap[w]);
            end
            checks++;
            if (wc[w] != 0 || fd_cnt[w] != 0 || fc_o[w] !== 8'd0 || busy_o[w] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_after_dut%0d got writes=%0d done=%0d cnt=%0d busy=%b required 0 0 0 0", w, wc[w], fd_cnt[w], fc_o[w], busy_o[w]);
            end
        end
        fill_ideal();
        for (int w = 0; w < 2; w++) model_frame(w, V, 1'b0);
        clear_counts();
        send_frame(V, -1, -1, -1);
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (wc[w] != 0) begin
                errors++;
                $display("[TB] FAIL midreset_unarmed_dut%0d got writes=%0d required 0", w, wc[w]);
            end
        end
    endtask

    task automatic test_random();
        int nl;
        for (int f = 0; f < 5; f++) begin
            fill_ideal();
            nl = $urandom_range(V - 1, V + 1);
            for (int l = 0; l < nl; l++) begin
                if ($urandom_range(0, 3) == 0) line_len[l] = $urandom_range(1, 2 * H + 3);
            end
            for (int w = 0; w < 2; w++) model_frame(w, nl, 1'b1);
            clear_counts();
            send_frame(nl, -2, -1, -1);
            exp_fc++;
            for (int w = 0; w < 2; w++) begin
                checks++;
                if (exp_q[w].size() != 0 || wc[w] != exp_n[w] || fd_cnt[w] != 1) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_frame_dut%0d got pending=%0d writes=%0d done=%0d required 0 %0d 1", f, w, exp_q[w].size(), wc[w], fd_cnt[w], exp_n[w]);
                end
                checks++;
                if (le_o[w] !== exp_le[w] || fe_o[w] !== exp_fe[w] || fc_o[w] !== 8'(exp_fc)) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_flags_dut%0d got le=%b fe=%b cnt=%0d required %b %b %0d", f, w, le_o[w], fe_o[w], fc_o[w], exp_le[w], exp_fe[w], exp_fc);
                end
                checks++;
                if (addr_o[w] != exp_last[w]) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_last_addr_dut%0d got %0d required %0d", f, w, addr_o[w], exp_last[w]);
                end
            end
        end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_continuous_frames();
        test_byte_swap_latency();
        test_line_errors();
        test_arm_midframe();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ov7670_capture_ctl.md
Name: ov7670_capture_ctl

Overview:
- Parametrised successor to the OV7670 byte-pair capture stage.
- Sits between the camera pins (pclk domain) and the frame-buffer BRAM write port.
- Pairs bytes into 16-bit RGB565 words, generates BRAM address and write enable, and supports optional 2x decimation.
- Adds single-shot/continuous arming, frame-done signalling, a frame counter, and line/frame geometry error flags.

Parameters:
- H_ACTIVE, 320, pixels per camera line (even).
- V_ACTIVE, 240, lines per camera frame.
- DEC, 1, decimation factor, 1 or 2. Keeps pixels with x%DEC==0 and y%DEC==0.
- BYTE_SWAP, 0, pairing order. 0: first byte of a pair goes to dout[15:8]. 1: first byte goes to dout[7:0].
- ADDR_W, 17, address width. Must satisfy 2^ADDR_W >= DEPTH.
- DEPTH is derived, not a parameter: DEPTH = (H_ACTIVE/DEC)*(V_ACTIVE/DEC).

Ports:
- pclk, in, 1, camera pixel clock; sole clock.
- rst, in, 1, synchronous, active-high reset.
- vsync, in, 1, frame sync; high = vertical blanking.
- href, in, 1, line valid; d is valid only while href=1.
- d, in, 8, camera data byte.
- arm, in, 1, one-cycle pulse; requests capture of the next full frame.
- continuous, in, 1, level; 1 = capture every frame without arm.
- addr, out, ADDR_W, BRAM write address.
- dout, out, 16, BRAM write data.
- we, out, 1, BRAM write enable.
- busy, out, 1, high in WAIT_VS or ACTIVE.
- frame_done, out, 1, one-cycle pulse at the end of a captured frame.
- frame_cnt, out, 8, count of completed captured frames; wraps 255->0.
- line_err, out, 1, sticky: some line had a wrong pixel count or an odd byte count.
- frame_err, out, 1, sticky: a frame ended with writes != DEPTH.

Behaviour:
- Reset values: state=IDLE; addr=0, dout=0, we=0, busy=0, frame_done=0, frame_cnt=0, line_err=0, frame_err=0. Internal vsync/href delay registers = 0.
- rst is sampled every pclk edge. Asserting rst mid-frame aborts the capture; no further we until re-armed.
- vsync and href are registered once internally. Edge detection uses the registered and current values.
- States:
  - IDLE -> WAIT_VS on arm=1 or continuous=1.
  - WAIT_VS -> ACTIVE on a vsync falling edge. The partial frame in progress when arming is never written.
  - ACTIVE -> DONE on a vsync rising edge.
  - DONE (1 cycle) -> WAIT_VS if continuous=1, else IDLE.
- Entering ACTIVE clears x, y, the write counter, byte phase, addr, line_err and frame_err.
- Byte phase:
  - Toggles on every pclk with href=1.
  - Forced to 0 whenever href=0, so each line starts on the first byte of a pair.
  - Phase-0 byte is held; the phase-1 byte completes the pixel.
- Pixel completion, per the BYTE_SWAP parameter:
  - BYTE_SWAP=0: pixel = {held, d}.
  - BYTE_SWAP=1: pixel = {d, held}.
  - x increments after each completed pixel.
- Write rule: on pixel completion in ACTIVE, if x%DEC==0, y%DEC==0 and write count < DEPTH:
  - next cycle: we=1, dout=pixel, addr=write count; then write count increments.
  - Latency: we asserts exactly 1 pclk after the second byte of the pair is sampled.
  - we is a single-cycle pulse per pixel. Never asserted outside ACTIVE.
- Saturation: once write count = DEPTH, writes are suppressed and addr holds DEPTH-1. No address wraps.
- href falling edge in ACTIVE:
  - line_err <= 1 if x != H_ACTIVE or phase=1 (odd byte; the dangling byte is discarded).
  - Then x <= 0 and y <= y+1.
- Frame end (vsync rising edge in ACTIVE):
  - frame_done pulses in the DONE cycle.
  - frame_cnt increments.
  - frame_err <= 1 if write count != DEPTH.
  - line_err and frame_err hold until the next entry to ACTIVE.
- vsync rising with href high: treated as a line end (line check applied) followed by frame end, in that order, same cycle.
- arm while busy=1 is ignored. continuous dropping mid-frame completes the current frame, then goes to IDLE.
- Arithmetic: x is a clog2(H_ACTIVE+1)-bit counter and saturates at H_ACTIVE on over-long lines. y uses the same scheme with V_ACTIVE. With DEC=2, use the low bit of x and y for the keep test.

Test Plan:
- Defaults, continuous=1, two ideal 320x240 frames. Expect 76800 we pulses per frame, addr 0..76799, frame_done twice, frame_cnt=2, no error flags.
- DEC=2, one armed frame. Expect 19200 writes, addr ends 19199, dout equals the even-row/even-column pixels only.
- BYTE_SWAP=0 vs 1, bytes 0xAB then 0xCD. Expect dout=0xABCD vs 0xCDAB, we exactly 1 cycle after 0xCD is sampled.
- One line of 319 pixels plus one with 641 bytes. Expect line_err=1; the odd byte is not written; the next line starts at the correct phase; frame_err=1 (76799 writes).
- arm pulsed mid-frame, continuous=0. Expect no we until after the next vsync falling edge, one frame captured, then IDLE with busy=0; a later arm while busy is ignored.
- rst asserted at pixel 1000 of an active frame. Expect all outputs 0 on the next edge, no we until the next arm plus vsync falling edge.
